// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// stage and the memory stage of the pipeline. Each requester holds its request
// until a one-cycle ready pulse. The memory stage has priority. A streak
// counter (dcount) limits how many data grants in a row may pass a waiting
// fetch, so fetch always makes progress.
//
// Optional feature macro: MEMARB_TIMEOUT_EN
//   defined   : a BUSY watchdog completes an access after TIMEOUT cycles with
//               no mem_ack, returns 32'hDEADBEEF for reads and sets sticky err.
//   undefined : BUSY waits for mem_ack forever, err is tied low.
//
// Parameters
//   MAXDGRANT  consecutive data grants allowed while ireq is pending
//   TIMEOUT    BUSY-cycle watchdog limit (timeout build only)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   ireq, iaddr                 fetch request / address
//   irdata, iready              fetch read data (registered) / ready pulse
//   dreq, dwe, daddr, dwdata    data request / write enable / address / data
//   drdata, dready              data read result (registered) / ready pulse
//   mem_req, mem_we             memory access valid / write enable
//   mem_addr, mem_wdata         latched address / write data to memory
//   mem_rdata, mem_ack          memory read data / completion
//   busy                        high while an access is in BUSY or DONE
//   err                         sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAXDGRANT = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        iready,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DCW = (MAXDGRANT > 0) ? $clog2(MAXDGRANT + 1) : 1;
    localparam logic [DCW-1:0] DCOUNT_MAX = DCW'(MAXDGRANT);

    logic [1:0]     r_state;
    logic           r_owner;      // 0 = fetch, 1 = data
    logic           r_we;
    logic [DCW-1:0] r_dcount;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_irdata;
    logic [31:0]    r_drdata;

    logic           w_grant_d;
    logic           w_expire;
    logic           w_complete;
    logic [31:0]    w_rdata_capture;
    logic [DCW-1:0] w_dcount_inc;

    // Data wins unless fetch is waiting and data has already used up its
    // allowance of consecutive grants.
    assign w_grant_d = dreq && (!ireq || (r_dcount < DCOUNT_MAX));

    // Saturating increment of the data streak.
    assign w_dcount_inc = (r_dcount == DCOUNT_MAX) ? r_dcount : r_dcount + 1'b1;

    // An ack in the expiry cycle takes precedence over the watchdog value.
    assign w_complete      = (r_state == ST_BUSY) && (mem_ack || w_expire);
    assign w_rdata_capture = mem_ack ? mem_rdata : 32'hDEADBEEF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_dcount <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_irdata <= '0;
            r_drdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_addr   <= daddr;
                        r_wdata  <= dwdata;
                        r_we     <= dwe;
                        r_owner  <= 1'b1;
                        r_state  <= ST_BUSY;
                        // The streak only counts grants that bypassed a
                        // waiting fetch.
                        r_dcount <= ireq ? w_dcount_inc : '0;
                    end else if (ireq) begin
                        r_addr   <= iaddr;
                        r_we     <= 1'b0;
                        r_owner  <= 1'b0;
                        r_dcount <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_complete) begin
                        if (!r_we) begin
                            if (r_owner) begin
                                r_drdata <= w_rdata_capture;
                            end else begin
                                r_irdata <= w_rdata_capture;
                            end
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TCW-1:0] TCOUNT_LAST = TCW'(TIMEOUT - 1);

    logic [TCW-1:0] r_tcount;
    logic           r_err;

    // r_tcount holds the number of BUSY cycles already elapsed; the cycle
    // in which it reads TIMEOUT-1 is the last one allowed.
    assign w_expire = (r_state == ST_BUSY) && !mem_ack && (r_tcount == TCOUNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcount <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != ST_BUSY) begin
                r_tcount <= '0;
            end else if (r_tcount != TCOUNT_LAST) begin
                r_tcount <= r_tcount + 1'b1;
            end
            if (w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign err              = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Moore decode of the handshake outputs.
    assign mem_req   = (r_state == ST_BUSY);
    assign mem_we    = (r_state == ST_BUSY) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign iready    = (r_state == ST_DONE) && !r_owner;
    assign dready    = (r_state == ST_DONE) && r_owner;
    assign busy      = (r_state == ST_BUSY) || (r_state == ST_DONE);
    assign irdata    = r_irdata;
    assign drdata    = r_drdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported unified instruction/data memory between the pipelined core's fetch stage and memory stage. Each side issues a request and holds it until a one-cycle ready pulse; while a request is pending and not yet ready, the hazard logic stalls the corresponding stage. The memory stage has priority over fetch, and a starvation counter guarantees fetch progress. It sits between the pipeline's fetch/memory stages and the external memory model.

## Interface
- `MAXDGRANT`, default 4: maximum consecutive data grants while `ireq` is pending before fetch is forced.
- `TIMEOUT`, default 16: BUSY-cycle limit for the watchdog; used only with `MEMARB_TIMEOUT_EN`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ireq` in 1: fetch request; held until `iready`.
- `iaddr` in 32: fetch address.
- `irdata` out 32: registered fetch read data.
- `iready` out 1: one-cycle completion pulse to fetch.
- `dreq` in 1: memory-stage request; held until `dready`.
- `dwe` in 1: 1 = write, 0 = read.
- `daddr` in 32: data address.
- `dwdata` in 32: write data.
- `drdata` out 32: registered data read result.
- `dready` out 1: one-cycle completion pulse to the memory stage.
- `mem_req` out 1: memory access valid.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: latched address.
- `mem_wdata` out 32: latched write data.
- `mem_rdata` in 32: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: memory completion.
- `busy` out 1: high in BUSY and DONE.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: `owner` (0 = fetch, 1 = data) and `dcount` of width $clog2(MAXDGRANT+1).
- **IDLE:**
  - With `dreq` asserted and (`!ireq` or `dcount < MAXDGRANT`): grant data. Latch `daddr`/`dwdata`/`dwe`, set `owner=1`, and go to BUSY. `dcount` increments (saturating) if `ireq` is asserted, else clears.
  - Otherwise, with `ireq` asserted: grant fetch. Latch `iaddr`, force `we=0`, set `owner=0`, clear `dcount`, and go to BUSY.
  - With no request: stay in IDLE. `dcount` is held.
- **BUSY:**
  - `mem_req=1`; `mem_addr`, `mem_wdata` and `mem_we` come from the latched values and are stable for the whole of BUSY.
  - On `mem_ack`: if the owner's access is a read, capture `mem_rdata` into `irdata` or `drdata` according to `owner`. Then go to DONE.
  - Write accesses leave `drdata` unchanged.
- **DONE:**
  - Assert `iready` (if `owner=0`) or `dready` (if `owner=1`) for exactly this cycle. `mem_req=0`. Go to IDLE.
- `mem_ack` is ignored in IDLE and DONE.
- Requests that change while BUSY are not re-sampled. Requesters must hold their request stable; behaviour is undefined otherwise.
- `mem_req`, `mem_we`, `iready`, `dready` and `busy` decode from the state (Moore style). There is no combinational path from any input to `mem_req`.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `iready`, `dready`, `busy`, `err` = 0; `irdata`, `drdata`, `mem_addr`, `mem_wdata` = 0; `dcount=0`; `owner=0`.
- Minimum access: request seen in IDLE at cycle 0 → `mem_req` in cycle 1 → `mem_ack` in cycle 1 → ready pulse in cycle 2 → IDLE in cycle 3. Back-to-back accesses therefore take 3 cycles each.
- Each extra wait cycle before `mem_ack` adds one cycle of latency.
- Read data is valid in `irdata`/`drdata` in the ready cycle and holds until the next read completion for that side.
- Simultaneous `ireq` and `dreq` in IDLE: data wins, unless `dcount == MAXDGRANT`, in which case fetch wins.
- Worst-case fetch starvation: `MAXDGRANT` data accesses.
- `reset` asserted mid-access: state returns to IDLE at that edge and `mem_req` drops. A pending `mem_ack` is discarded, and no ready pulse is issued for the aborted access.

## Configuration
- **`MEMARB_TIMEOUT_EN` defined:**
  - A BUSY-cycle counter clears on entry to BUSY.
  - If `TIMEOUT` BUSY cycles elapse without `mem_ack`, the FSM goes to DONE. The owner's read data register is loaded with 32'hDEADBEEF for reads; writes do not update data registers.
  - The normal ready pulse is issued, and `err` is set and stays high until `reset`.
  - An ack arriving in the same cycle as expiry wins: the access completes normally and `err` is not set.
- **Not defined:** BUSY waits indefinitely for `mem_ack`. `err` is tied to 0 and the `TIMEOUT` parameter is unused. The port list is identical in both builds.

## Test plan
- Reset, then a fetch read of 0x00000040 with the memory returning 0x8C080004 on the first BUSY cycle → `iready` pulses at cycle 2 with `irdata`=0x8C080004, `mem_we`=0 throughout.
- `ireq` and `dreq` (read of 0x100) raised together → data granted first and `dready` pulses; fetch is granted in the next IDLE and `iready` follows 3 cycles later.
- Continuous `dreq` and `ireq` with `MAXDGRANT`=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Data write of 0xCAFEF00D to 0x200 with `mem_ack` delayed 3 cycles → `mem_req`/`mem_we` held 4 cycles with stable address/data; `dready` pulses once; `drdata` unchanged.
- `reset` asserted in the second BUSY cycle, with `mem_ack` high in the following cycle → `mem_req` is low after the reset edge, and no `iready`/`dready` pulse occurs.
- With `MEMARB_TIMEOUT_EN` and `TIMEOUT`=16, a data read that is never acked → `dready` pulses after 16 BUSY cycles, `drdata`=0xDEADBEEF, `err`=1 and stays high until `reset`.
